// File: rtl/video_mixer_pkg.sv
// video_mixer_pkg
//   Shared types, colour-space coefficients, clamp bounds and small helpers
//   used by the video output mixer pipeline (video_mixer_pipe and its
//   rgb2ypbpr_pipe converter).
package video_mixer_pkg;

    // BT.601 limited-range coefficients (x256)
    localparam int LIM_YR  = 66;
    localparam int LIM_YG  = 129;
    localparam int LIM_YB  = 25;
    localparam int LIM_PBR = -38;
    localparam int LIM_PBG = -74;
    localparam int LIM_PBB = 112;
    localparam int LIM_PRR = 112;
    localparam int LIM_PRG = -94;
    localparam int LIM_PRB = -18;

    // Full-range coefficients (x256)
    localparam int FULL_YR  = 77;
    localparam int FULL_YG  = 150;
    localparam int FULL_YB  = 29;
    localparam int FULL_PBR = -43;
    localparam int FULL_PBG = -85;
    localparam int FULL_PBB = 128;
    localparam int FULL_PRR = 128;
    localparam int FULL_PRG = -107;
    localparam int FULL_PRB = -21;

    // Offsets and clamp bounds
    localparam int Y_OFS_LIM = 16;
    localparam int C_OFS     = 128;
    localparam int LIM_MIN   = 16;
    localparam int Y_MAX_LIM = 235;
    localparam int C_MAX_LIM = 240;

    typedef enum logic [1:0] {
        SL_NONE = 2'b00,
        SL_25   = 2'b01,
        SL_50   = 2'b10,
        SL_75   = 2'b11
    } sl_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Per-pixel sideband carried alongside colour; mode bits ride with the
    // pixel so a mode change mid-pipe never mixes settings within one pixel.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ypbpr;
        logic full;
        logic csync;
    } ctl_t;

    // Right-aligned width-bit value -> 8 bits by repeating its MSBs downward.
    function automatic logic [7:0] expand_to8(input logic [7:0] value, input int width);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = value[3'(width - 1 - (i % width))];
        end
        return res;
    endfunction

    function automatic logic [7:0] clamp8(input int v, input int lo, input int hi);
        if (v < lo)      return 8'(lo);
        else if (v > hi) return 8'(hi);
        else             return 8'(v);
    endfunction

    function automatic logic [7:0] dim8(input logic [7:0] x, input sl_mode_e m);
        case (m)
            SL_25:   return (x >> 1) + (x >> 2);
            SL_50:   return x >> 1;
            SL_75:   return x >> 2;
            default: return x;
        endcase
    endfunction

    // Signed weighted sum of three unsigned 8-bit channels, 18-bit result.
    function automatic logic signed [17:0] mac3(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b, input int kr,
                                                input int kg, input int kb);
        int s;
        s = kr * int'(r) + kg * int'(g) + kb * int'(b);
        return 18'(s);
    endfunction

endpackage

// File: rtl/video_mixer_pipe_rgb2ypbpr.sv
// rgb2ypbpr_pipe
//   Two-stage RGB -> YPbPr converter, advancing only on ce_pix.
//   Stage A: 18-bit signed weighted sums, arithmetic >>8 (floor).
//   Stage B: offset and clamp for limited or full range.
// Ports:
//   clk_sys, reset (sync, active-high), ce_pix
//   i_pix   8-bit RGB in          i_full  1 = full range, 0 = limited
//   o_y, o_pb, o_pr               8-bit components, 2 ce_pix pulses later
module rgb2ypbpr_pipe
    import video_mixer_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_pix,
    input  rgb8_t      i_pix,
    input  logic       i_full,
    output logic [7:0] o_y,
    output logic [7:0] o_pb,
    output logic [7:0] o_pr
);

    logic signed [17:0] w_y_sum, w_pb_sum, w_pr_sum;
    logic signed [17:0] r_y, r_pb, r_pr;
    logic               r_full;
    logic [7:0]         w_y, w_pb, w_pr;
    logic [7:0]         r_y_o, r_pb_o, r_pr_o;

    always_comb begin
        if (i_full) begin
            w_y_sum  = mac3(i_pix.r, i_pix.g, i_pix.b, FULL_YR,  FULL_YG,  FULL_YB);
            w_pb_sum = mac3(i_pix.r, i_pix.g, i_pix.b, FULL_PBR, FULL_PBG, FULL_PBB);
            w_pr_sum = mac3(i_pix.r, i_pix.g, i_pix.b, FULL_PRR, FULL_PRG, FULL_PRB);
        end else begin
            w_y_sum  = mac3(i_pix.r, i_pix.g, i_pix.b, LIM_YR,  LIM_YG,  LIM_YB);
            w_pb_sum = mac3(i_pix.r, i_pix.g, i_pix.b, LIM_PBR, LIM_PBG, LIM_PBB);
            w_pr_sum = mac3(i_pix.r, i_pix.g, i_pix.b, LIM_PRR, LIM_PRG, LIM_PRB);
        end
    end

    always_comb begin
        if (r_full) begin
            w_y  = clamp8(int'(r_y), 0, 255);
            w_pb = clamp8(int'(r_pb) + C_OFS, 0, 255);
            w_pr = clamp8(int'(r_pr) + C_OFS, 0, 255);
        end else begin
            w_y  = clamp8(int'(r_y) + Y_OFS_LIM, LIM_MIN, Y_MAX_LIM);
            w_pb = clamp8(int'(r_pb) + C_OFS, LIM_MIN, C_MAX_LIM);
            w_pr = clamp8(int'(r_pr) + C_OFS, LIM_MIN, C_MAX_LIM);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_y    <= '0;
            r_pb   <= '0;
            r_pr   <= '0;
            r_full <= 1'b0;
            r_y_o  <= '0;
            r_pb_o <= '0;
            r_pr_o <= '0;
        end else if (ce_pix) begin
            r_y    <= w_y_sum >>> 8;
            r_pb   <= w_pb_sum >>> 8;
            r_pr   <= w_pr_sum >>> 8;
            r_full <= i_full;
            r_y_o  <= w_y;
            r_pb_o <= w_pb;
            r_pr_o <= w_pr;
        end
    end

    assign o_y  = r_y_o;
    assign o_pb = r_pb_o;
    assign o_pr = r_pr_o;

endmodule

// File: rtl/video_mixer_pipe.sv
// video_mixer_pipe
//   Video output mixer: widens colour to 8 bits, applies blanking and
//   scanline dimming, optionally converts to YPbPr, and drives the VGA pins
//   with a fixed 3-ce_pix latency in every mode.
// Ports:
//   clk_sys, reset (sync, active-high, wins over ce_pix), ce_pix
//   r_in/g_in/b_in [IN_W]   input colour
//   hs_in, vs_in            positive syncs      hblank, vblank  blanking
//   scanlines [2]           00/01/10/11 = none/25/50/75 % reduction
//   ypbpr, ypbpr_full, csync_en   output mode selects
//   VGA_R/G/B [OUT_W]       Pr/Y/Pb in YPbPr mode, else R/G/B
//   VGA_HS, VGA_VS          negative syncs      VGA_DE  active video
module video_mixer_pipe
    import video_mixer_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 6
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [IN_W-1:0]  r_in,
    input  logic [IN_W-1:0]  g_in,
    input  logic [IN_W-1:0]  b_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [1:0]       scanlines,
    input  logic             ypbpr,
    input  logic             ypbpr_full,
    input  logic             csync_en,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE
);

    localparam int STAGES = 3;

    // Scanline tracker
    logic     r_hs_prev, r_vs_prev, r_flag;
    logic     w_hs_fall, w_vs_fall, w_flag_nxt;
    sl_mode_e w_dim_mode;

    // Stage 1 combinational
    logic [7:0] w_exp_r, w_exp_g, w_exp_b;
    logic       w_blank;
    rgb8_t      w_s1_pix;
    ctl_t       w_s1_ctl;

    // Pipeline registers, index = stage number
    rgb8_t r_pix [1:STAGES];
    ctl_t  r_ctl [1:STAGES];

    logic [7:0] w_y, w_pb, w_pr;
    rgb8_t      w_out;
    logic       w_comp_sync;

    assign w_hs_fall = r_hs_prev & ~hs_in;
    assign w_vs_fall = r_vs_prev & ~vs_in;

    // Clear beats toggle; the new flag applies from the very pixel on
    // which the edge is seen, so whole lines are dimmed uniformly.
    always_comb begin
        w_flag_nxt = r_flag;
        if (w_vs_fall)      w_flag_nxt = 1'b0;
        else if (w_hs_fall) w_flag_nxt = ~r_flag;
    end

    always_comb begin
        w_exp_r    = expand_to8(8'(r_in), IN_W);
        w_exp_g    = expand_to8(8'(g_in), IN_W);
        w_exp_b    = expand_to8(8'(b_in), IN_W);
        w_blank    = hblank | vblank;
        w_dim_mode = w_flag_nxt ? sl_mode_e'(scanlines) : SL_NONE;
        w_s1_pix.r = w_blank ? 8'd0 : dim8(w_exp_r, w_dim_mode);
        w_s1_pix.g = w_blank ? 8'd0 : dim8(w_exp_g, w_dim_mode);
        w_s1_pix.b = w_blank ? 8'd0 : dim8(w_exp_b, w_dim_mode);
        w_s1_ctl.hs    = hs_in;
        w_s1_ctl.vs    = vs_in;
        w_s1_ctl.de    = ~w_blank;
        w_s1_ctl.ypbpr = ypbpr;
        w_s1_ctl.full  = ypbpr_full;
        w_s1_ctl.csync = csync_en;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_flag    <= 1'b0;
            for (int s = 1; s <= STAGES; s++) begin
                r_pix[s] <= '0;
                r_ctl[s] <= '0;
            end
        end else if (ce_pix) begin
            r_hs_prev <= hs_in;
            r_vs_prev <= vs_in;
            r_flag    <= w_flag_nxt;
            r_pix[1]  <= w_s1_pix;
            r_ctl[1]  <= w_s1_ctl;
            for (int s = 2; s <= STAGES; s++) begin
                r_pix[s] <= r_pix[s-1];
                r_ctl[s] <= r_ctl[s-1];
            end
        end
    end

    // Converter runs on every pixel; its 2-pulse latency lines up with
    // stage 3 of the RGB bypass, so both modes share the same latency.
    rgb2ypbpr_pipe u_conv (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .i_pix   (r_pix[1]),
        .i_full  (r_ctl[1].full),
        .o_y     (w_y),
        .o_pb    (w_pb),
        .o_pr    (w_pr)
    );

    always_comb begin
        if (r_ctl[STAGES].ypbpr) begin
            w_out.r = w_pr;
            w_out.g = w_y;
            w_out.b = w_pb;
        end else begin
            w_out = r_pix[STAGES];
        end
        w_comp_sync = r_ctl[STAGES].ypbpr | r_ctl[STAGES].csync;
    end

    assign VGA_R  = w_out.r[7 -: OUT_W];
    assign VGA_G  = w_out.g[7 -: OUT_W];
    assign VGA_B  = w_out.b[7 -: OUT_W];
    assign VGA_HS = w_comp_sync ? ~(r_ctl[STAGES].hs ^ r_ctl[STAGES].vs) : ~r_ctl[STAGES].hs;
    assign VGA_VS = w_comp_sync ? 1'b1 : ~r_ctl[STAGES].vs;
    assign VGA_DE = r_ctl[STAGES].de;

endmodule

// File: doc/video_mixer_pipe.md
Name: video_mixer_pipe

Overview:
Parametrised, pipelined successor to the core's video output mixer. It takes already-scandoubled (or native 15 kHz) RGB with syncs and blanks, and widens colour to an internal 8-bit path. It applies blanking and four-level scanline dimming, optionally converts to YPbPr (limited or full range), and drives the MiST VGA pins with a fixed, mode-independent latency. Sits between the scandoubler output and the board video DAC.

Parameters:
IN_W, 6, input colour bits per channel (1..8)
OUT_W, 6, output colour bits per channel (1..8)

Ports:
clk_sys  in  1  master clock
reset  in  1  synchronous active-high reset
ce_pix  in  1  pixel clock enable; pipeline advances only when high
r_in, g_in, b_in  in  IN_W each  input colour
hs_in, vs_in  in  1  positive sync pulses
hblank, vblank  in  1  blanking; either high forces colour to 0
scanlines  in  2  00 none, 01 25%, 10 50%, 11 75% reduction
ypbpr  in  1  1 = YPbPr output with composite sync on HS
ypbpr_full  in  1  1 = full 0-255 range, 0 = BT.601 limited range
csync_en  in  1  1 = composite sync on VGA_HS in RGB mode (15 kHz)
VGA_R, VGA_G, VGA_B  out  OUT_W each  Pr/Y/Pb when ypbpr=1, else R/G/B
VGA_HS, VGA_VS  out  1  negative-polarity syncs
VGA_DE  out  1  active video, aligned with colour

Behaviour:
- Reset (sync, active-high; wins over ce_pix): all pipeline registers cleared; VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_DE=0; scanline flag=0; edge-detect history=0.
- All state updates only on clk_sys edges with ce_pix=1 (except reset). Latency is exactly 3 ce_pix pulses from input to output for colour, syncs and DE, in every mode. Mode inputs are sampled at stage 1 and carried down the pipe, so a mode change never tears a pixel.
- Stage 1:
  - Expand each channel to 8 bits by MSB replication, e.g. 6-bit c -> {c, c[5:4]}. IN_W=8 passes through.
  - Blank: force the channel to 0 if hblank|vblank. DE = ~(hblank|vblank).
  - Dim when the scanline flag=1: 01 -> x/2 + x/4; 10 -> x/2; 11 -> x/4 (integer shifts on 8 bits). Flag=0 or scanlines=00: unchanged.
- Scanline flag: toggles on each hs_in falling edge and clears on each vs_in falling edge. Both edges are detected against the previous ce_pix-sampled value. If both fall in the same sample, clear wins (flag=0). The first line after a vsync is therefore undimmed.
- Stage 2: signed 18-bit sums of 8-bit unsigned colour with these coefficients.
  - Limited range: Y=(66R+129G+25B), Pb=(-38R-74G+112B), Pr=(112R-94G-18B).
  - Full range: Y=(77R+150G+29B), Pb=(-43R-85G+128B), Pr=(128R-107G-21B).
  - Arithmetic shift right 8 (floor).
- Stage 3, YPbPr offsets and clamp:
  - Limited range: Y+16 clamped to 16..235; Pb/Pr +128 clamped to 16..240.
  - Full range: Y clamped to 0..255; Pb/Pr +128 clamped to 0..255.
  - ypbpr=0 bypasses to the stage-1 RGB, delayed.
- Output reduction: top OUT_W bits of the 8-bit value, e.g. OUT_W=6 -> v[7:2]. For OUT_W=8, pass through.
- Sync outputs (from delayed hs/vs):
  - ypbpr=1: VGA_HS=~(hs^vs), VGA_VS=1.
  - ypbpr=0, csync_en=1: VGA_HS=~(hs^vs), VGA_VS=1.
  - Otherwise: VGA_HS=~hs, VGA_VS=~vs.
- Blanking is applied before conversion. In limited mode, blanked pixels therefore output Y=16 and Pb=Pr=128, which is correct black.
- ce_pix stuck low: outputs hold their last values indefinitely.

Decomposition:
- Package video_mixer_pkg:
  - Coefficient localparams for both ranges.
  - Clamp bounds (16/235/240).
  - Scanline mode enum (SL_NONE, SL_25, SL_50, SL_75).
  - Function expand_to8(value, width).
- One sub-module, rgb2ypbpr_pipe: stages 2-3 for one pixel, 2-cycle latency, ce-gated. Instantiated once per pixel stream.
- Top level holds stage 1, the scanline tracker, sync/DE delay lines and output muxing.

Test Plan:
1. IN_W=6, OUT_W=6, RGB mode, r/g/b=63, no blank, scanlines=00 -> after exactly 3 ce_pix pulses VGA_R/G/B=63, VGA_DE=1.
2. Same white input, scanlines=10, after one hs_in falling edge -> that line outputs 31 (255>>1=127 -> 127>>2); next line 63; a vs_in fall resets so the first line is undimmed.
3. ypbpr=1, ypbpr_full=0: white -> VGA_G=58 (Y=235), VGA_B=VGA_R=32 (128). Black -> VGA_G=4 (Y=16), VGA_B=VGA_R=32. Pure red (63,0,0) -> VGA_R=59 (Pr=239).
4. ypbpr=1, ypbpr_full=1: white -> VGA_G=63, VGA_B=VGA_R=32. hs_in=1 with vs_in=0 -> VGA_HS=0, VGA_VS=1.
5. hblank=1 with white input -> RGB mode 0/0/0 and VGA_DE=0. Simultaneous hs/vs falling edges -> flag=0. csync_en=1 in RGB mode -> VGA_HS=~(hs^vs).
6. Assert reset mid-frame with ce_pix=0 -> next clk_sys edge outputs 0/0/0, HS=VS=1, DE=0. After release, the first valid pixel appears exactly 3 ce_pix pulses later.
